// File: rtl/sysid_boot_checker_pkg.sv
// Shared definitions for the sysid boot checker: FSM encoding, sysid word
// addresses and counter widths sized for the largest legal parameter values.
package sysid_boot_checker_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_REQ_ID  = 3'd1;
    localparam state_t ST_WAIT_ID = 3'd2;
    localparam state_t ST_REQ_TS  = 3'd3;
    localparam state_t ST_WAIT_TS = 3'd4;
    localparam state_t ST_EVAL    = 3'd5;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int MAX_TIMEOUT_CYCLES = 65535;
    localparam int MAX_READ_LATENCY   = 7;
    localparam int MAX_RETRY_LIMIT    = 15;

    localparam int STALL_W = $clog2(MAX_TIMEOUT_CYCLES + 1);
    localparam int LAT_W   = $clog2(MAX_READ_LATENCY + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY_LIMIT + 1);

endpackage

// File: rtl/sysid_read_port.sv
// Single-word Avalon-MM read engine: holds the strobe while the slave stalls,
// aborts after TIMEOUT_CYCLES stalls and flags the readdata beat after READ_LATENCY.
module sysid_read_port
    import sysid_boot_checker_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue,
    input  logic        waiting,
    input  logic        addr,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        m_read,
    output logic        m_address,
    output logic        accepted,
    output logic        data_valid,
    output logic        timeout,
    output logic [31:0] data
);

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               stalled;

    always_comb begin
        m_read    = issue;
        m_address = issue & addr;
        accepted  = issue & ~m_waitrequest;
        stalled   = issue & m_waitrequest;
        // Abort in the cycle that completes the TIMEOUT_CYCLES-th stall.
        timeout   = stalled && (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1));
        stall_cnt_d = stalled ? stall_cnt_q + 1'b1 : '0;
        lat_cnt_d   = waiting ? lat_cnt_q + 1'b1 : '0;
        if (READ_LATENCY == 0) begin
            data_valid = accepted;
        end else begin
            data_valid = waiting && (lat_cnt_q == LAT_W'(READ_LATENCY - 1));
        end
        data = m_readdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            lat_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid check: reads the ID and build timestamp words, compares them
// with the expected build values, retries on mismatch and reports a sticky result.
module sysid_boot_checker
    import sysid_boot_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1456594139,
    parameter int          READ_LATENCY       = 1,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        err_id,
    output logic        err_ts,
    output logic        err_timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    state_t             state_q, state_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic               boot_q, boot_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               err_id_q, err_id_d;
    logic               err_ts_q, err_ts_d;
    logic               err_timeout_q, err_timeout_d;
    logic [31:0]        captured_id_q, captured_id_d;
    logic [31:0]        captured_ts_q, captured_ts_d;

    logic        rp_issue, rp_waiting, rp_addr;
    logic        rp_accepted, rp_data_valid, rp_timeout;
    logic [31:0] rp_data;

    sysid_read_port #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read_port (
        .clock         (clock),
        .reset         (reset),
        .issue         (rp_issue),
        .waiting       (rp_waiting),
        .addr          (rp_addr),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .m_read        (m_read),
        .m_address     (m_address),
        .accepted      (rp_accepted),
        .data_valid    (rp_data_valid),
        .timeout       (rp_timeout),
        .data          (rp_data)
    );

    always_comb begin
        rp_issue   = (state_q == ST_REQ_ID) || (state_q == ST_REQ_TS);
        rp_waiting = (state_q == ST_WAIT_ID) || (state_q == ST_WAIT_TS);
        rp_addr    = (state_q == ST_REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

        state_d       = state_q;
        retry_cnt_d   = retry_cnt_q;
        boot_d        = 1'b0;
        done_d        = 1'b0;
        pass_d        = pass_q;
        err_id_d      = err_id_q;
        err_ts_d      = err_ts_q;
        err_timeout_d = err_timeout_q;
        captured_id_d = captured_id_q;
        captured_ts_d = captured_ts_q;

        case (state_q)
            ST_IDLE: begin
                // boot_q supplies the automatic check after reset; done_q blocks restarts in the done cycle.
                if ((start || boot_q) && !done_q) begin
                    state_d       = ST_REQ_ID;
                    retry_cnt_d   = '0;
                    pass_d        = 1'b0;
                    err_id_d      = 1'b0;
                    err_ts_d      = 1'b0;
                    err_timeout_d = 1'b0;
                end
            end
            ST_REQ_ID, ST_WAIT_ID: begin
                if (rp_timeout) begin
                    err_timeout_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = ST_IDLE;
                end else if (rp_data_valid) begin
                    captured_id_d = rp_data;
                    state_d       = ST_REQ_TS;
                end else if (rp_accepted) begin
                    state_d = ST_WAIT_ID;
                end
            end
            ST_REQ_TS, ST_WAIT_TS: begin
                if (rp_timeout) begin
                    err_timeout_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = ST_IDLE;
                end else if (rp_data_valid) begin
                    captured_ts_d = rp_data;
                    state_d       = ST_EVAL;
                end else if (rp_accepted) begin
                    state_d = ST_WAIT_TS;
                end
            end
            ST_EVAL: begin
                if ((captured_id_q == EXPECTED_ID) && (captured_ts_q == EXPECTED_TIMESTAMP)) begin
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (retry_cnt_q < RETRY_W'(MAX_RETRIES)) begin
                    retry_cnt_d = retry_cnt_q + 1'b1;
                    state_d     = ST_REQ_ID;
                end else begin
                    err_id_d = (captured_id_q != EXPECTED_ID);
                    err_ts_d = (captured_ts_q != EXPECTED_TIMESTAMP);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            retry_cnt_q   <= '0;
            boot_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_id_q      <= 1'b0;
            err_ts_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            captured_id_q <= '0;
            captured_ts_q <= '0;
        end else begin
            state_q       <= state_d;
            retry_cnt_q   <= retry_cnt_d;
            boot_q        <= boot_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_id_q      <= err_id_d;
            err_ts_q      <= err_ts_d;
            err_timeout_q <= err_timeout_d;
            captured_id_q <= captured_id_d;
            captured_ts_q <= captured_ts_d;
        end
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = done_q;
        pass        = pass_q;
        err_id      = err_id_q;
        err_ts      = err_ts_q;
        err_timeout = err_timeout_q;
        captured_id = captured_id_q;
        captured_ts = captured_ts_q;
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: a behavioural Avalon sysid slave with stall and
// latency control, directed scenarios, and randomized checks against a pass-count model.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1456594139;
    localparam int L  = 2;
    localparam int TO = 4;
    localparam int MR = 2;

    logic        clock, reset, start;
    logic        m_address, m_read, m_waitrequest;
    logic [31:0] m_readdata;
    logic        busy, done, pass, err_id, err_ts, err_timeout;
    logic [31:0] captured_id, captured_ts;

    int checks = 0;
    int failures = 0;

    // Slave configuration and observation
    int          stall_cfg = 0;
    bit          stuck = 0;
    int          id_bad = 0, ts_bad = 0;
    logic [31:0] bad_id = 32'hdead_beef, bad_ts = 32'h1234_5678;
    int          id_seen = 0, ts_seen = 0;
    int          log_q[$];
    int          stall_seen = 0, drop_cnt = 0, done_cnt = 0;

    sysid_boot_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .READ_LATENCY       (L),
        .TIMEOUT_CYCLES     (TO),
        .MAX_RETRIES        (MR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_id        (err_id),
        .err_ts        (err_ts),
        .err_timeout   (err_timeout),
        .captured_id   (captured_id),
        .captured_ts   (captured_ts)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // Slave: decides at each falling edge what the DUT will see at the next rising edge.
    initial begin : slave
        bit          in_req, pending, acc_prev, prev_stalled;
        int          k, stall_left;
        logic [31:0] cur, data_next;
        in_req = 0; pending = 0; acc_prev = 0; prev_stalled = 0;
        k = 0; stall_left = 0; cur = 0; data_next = 0;
        m_waitrequest = 0;
        m_readdata = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_req = 0; pending = 0; acc_prev = 0; prev_stalled = 0;
                m_waitrequest = 0;
                continue;
            end
            if (acc_prev) begin
                pending = 1; k = 0; cur = data_next;
            end else if (pending) begin
                k++;
            end
            m_readdata = (pending && k == L - 1) ? cur : ~cur;
            if (pending && k >= L - 1) pending = 0;
            acc_prev = 0;
            if (prev_stalled && !m_read) drop_cnt++;
            if (m_read) begin
                if (!in_req) begin
                    in_req = 1;
                    stall_left = stall_cfg;
                end
                if (stuck || stall_left > 0) begin
                    m_waitrequest = 1;
                    stall_left--;
                    stall_seen++;
                    prev_stalled = 1;
                end else begin
                    m_waitrequest = 0;
                    prev_stalled = 0;
                    in_req = 0;
                    acc_prev = 1;
                    log_q.push_back(int'(m_address));
                    if (m_address == 1'b0) begin
                        id_seen++;
                        data_next = (id_seen <= id_bad) ? bad_id : EXP_ID;
                    end else begin
                        ts_seen++;
                        data_next = (ts_seen <= ts_bad) ? bad_ts : EXP_TS;
                    end
                end
            end else begin
                m_waitrequest = 1'($urandom_range(0, 1));
                in_req = 0;
                prev_stalled = 0;
            end
        end
    end

    always @(negedge clock) if (done === 1'b1) done_cnt++;

    task automatic cfg(input int stall, input bit stk, input int idb, input int tsb);
        stall_cfg = stall; stuck = stk; id_bad = idb; ts_bad = tsb;
        id_seen = 0; ts_seen = 0; stall_seen = 0; drop_cnt = 0;
        log_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
    endtask

    // Waits for the done pulse; reports busy in that cycle and done one cycle later.
    task automatic wait_done(output bit ok, output logic busy_at_done, output logic done_after);
        ok = 0; busy_at_done = 1'bx; done_after = 1'bx;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        busy_at_done = busy;
        @(negedge clock);
        done_after = done;
    endtask

    function automatic bit log_alternates(input int n);
        if (log_q.size() != n) return 0;
        for (int i = 0; i < n; i++) if (log_q[i] != (i % 2)) return 0;
        return 1;
    endfunction

    task automatic test_reset();
        checks++;
        if ({busy, done, pass, err_id, err_ts, err_timeout, m_read, m_address} !== 8'h00 ||
            captured_id !== 32'h0 || captured_ts !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b id=%h ts=%h exp=all zero",
                     {busy, done, pass, err_id, err_ts, err_timeout, m_read, m_address}, captured_id, captured_ts);
        end
    endtask

    task automatic test_auto_boot();
        bit ok; logic b, d2;
        cfg(0, 0, 0, 0);
        @(negedge clock) reset = 0;
        wait_done(ok, b, d2);
        checks++;
        if (!ok) begin failures++; $display("FAIL boot_done got=none exp=pulse"); end
        checks++;
        if (b !== 1'b0 || d2 !== 1'b0) begin failures++; $display("FAIL boot_done_shape busy=%b next_done=%b exp=0 0", b, d2); end
        checks++;
        if ({pass, err_id, err_ts, err_timeout} !== 4'b1000) begin
            failures++; $display("FAIL boot_flags got=%b exp=1000", {pass, err_id, err_ts, err_timeout});
        end
        checks++;
        if (captured_id !== EXP_ID || captured_ts !== EXP_TS) begin
            failures++; $display("FAIL boot_capture got=%h/%h exp=%h/%h", captured_id, captured_ts, EXP_ID, EXP_TS);
        end
        checks++;
        if (!log_alternates(2)) begin failures++; $display("FAIL boot_addr_seq reads=%0d exp=2 (0,1)", log_q.size()); end
    endtask

    task automatic test_stall();
        bit ok; logic b, d2;
        cfg(3, 0, 0, 0);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy); end
        wait_done(ok, b, d2);
        checks++;
        if (!ok || b !== 1'b0 || pass !== 1'b1) begin
            failures++; $display("FAIL stall_result done=%b busy=%b pass=%b exp=1 0 1", ok, b, pass);
        end
        checks++;
        if (stall_seen != 6 || drop_cnt != 0) begin
            failures++; $display("FAIL stall_hold stalls=%0d drops=%0d exp=6 0", stall_seen, drop_cnt);
        end
        checks++;
        if (captured_ts !== EXP_TS || !log_alternates(2)) begin
            failures++; $display("FAIL stall_capture ts=%h reads=%0d exp=%h 2", captured_ts, log_q.size(), EXP_TS);
        end
    endtask

    task automatic test_retry_exhaust();
        bit ok; logic b, d2;
        cfg(0, 0, 0, 99);
        bad_ts = 32'h1234_5678;
        pulse_start();
        wait_done(ok, b, d2);
        checks++;
        if (!ok || {pass, err_id, err_ts, err_timeout} !== 4'b0010) begin
            failures++; $display("FAIL exhaust_flags done=%b got=%b exp=0010", ok, {pass, err_id, err_ts, err_timeout});
        end
        checks++;
        if (!log_alternates(6)) begin failures++; $display("FAIL exhaust_reads got=%0d exp=6", log_q.size()); end
        checks++;
        if (captured_ts !== 32'h1234_5678 || captured_id !== EXP_ID) begin
            failures++; $display("FAIL exhaust_capture got=%h/%h exp=%h/12345678", captured_id, captured_ts, EXP_ID);
        end
    endtask

    task automatic test_one_retry();
        bit ok; logic b, d2;
        cfg(1, 0, 0, 1);
        pulse_start();
        wait_done(ok, b, d2);
        checks++;
        if (!ok || {pass, err_id, err_ts, err_timeout} !== 4'b1000) begin
            failures++; $display("FAIL retry_flags done=%b got=%b exp=1000", ok, {pass, err_id, err_ts, err_timeout});
        end
        checks++;
        if (!log_alternates(4)) begin failures++; $display("FAIL retry_reads got=%0d exp=4", log_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok; logic b, d2;
        cfg(0, 1, 0, 0);
        pulse_start();
        wait_done(ok, b, d2);
        stuck = 0;
        checks++;
        if (!ok || b !== 1'b0 || d2 !== 1'b0) begin
            failures++; $display("FAIL timeout_done done=%b busy=%b next_done=%b exp=1 0 0", ok, b, d2);
        end
        checks++;
        if ({pass, err_id, err_ts, err_timeout} !== 4'b0001) begin
            failures++; $display("FAIL timeout_flags got=%b exp=0001", {pass, err_id, err_ts, err_timeout});
        end
        checks++;
        if (stall_seen != TO || drop_cnt != 1 || log_q.size() != 0) begin
            failures++; $display("FAIL timeout_stalls stalls=%0d drops=%0d reads=%0d exp=%0d 1 0", stall_seen, drop_cnt, log_q.size(), TO);
        end
    endtask

    task automatic test_start_ignored();
        bit ok; bit stayed_idle;
        cfg(2, 0, 0, 0);
        pulse_start();
        @(negedge clock);
        start = 1;
        @(negedge clock) start = 0;
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin ok = 1; break; end
        end
        start = 1;
        @(negedge clock) start = 0;
        stayed_idle = 1;
        for (int c = 0; c < 5; c++) begin
            if (busy !== 1'b0) stayed_idle = 0;
            @(negedge clock);
        end
        checks++;
        if (!ok || !stayed_idle || pass !== 1'b1) begin
            failures++; $display("FAIL ignore_start done=%b idle_after=%b pass=%b exp=1 1 1", ok, stayed_idle, pass);
        end
        checks++;
        if (!log_alternates(2)) begin failures++; $display("FAIL ignore_start_reads got=%0d exp=2", log_q.size()); end
    endtask

    task automatic test_reset_midcheck();
        bit ok, seen; logic b, d2; int d0;
        cfg(0, 0, 0, 0);
        pulse_start();
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (log_q.size() == 2) begin seen = 1; break; end
            @(negedge clock);
        end
        @(negedge clock);
        reset = 1;
        #1;
        checks++;
        if (!seen || {busy, done, pass, err_id, err_ts, err_timeout, m_read, m_address} !== 8'h00 ||
            captured_id !== 32'h0 || captured_ts !== 32'h0) begin
            failures++;
            $display("FAIL midreset_outputs reached=%b got=%b id=%h ts=%h exp=all zero", seen,
                     {busy, done, pass, err_id, err_ts, err_timeout, m_read, m_address}, captured_id, captured_ts);
        end
        d0 = done_cnt;
        repeat (3) @(negedge clock);
        checks++;
        if (done_cnt != d0) begin failures++; $display("FAIL midreset_no_done pulses=%0d exp=0", done_cnt - d0); end
        cfg(0, 0, 0, 0);
        reset = 0;
        wait_done(ok, b, d2);
        checks++;
        if (!ok || pass !== 1'b1 || !log_alternates(2)) begin
            failures++; $display("FAIL midreset_restart done=%b pass=%b reads=%0d exp=1 1 2", ok, pass, log_q.size());
        end
    endtask

    task automatic test_random();
        bit ok; logic b, d2;
        int idb, tsb, worst, npass;
        bit good;
        logic [3:0] exp_flags;
        logic [31:0] exp_cid, exp_cts;
        for (int it = 0; it < 16; it++) begin
            idb = $urandom_range(0, 3);
            tsb = $urandom_range(0, 3);
            cfg($urandom_range(0, 3), 0, idb, tsb);
            bad_id = $urandom | 32'h1;
            bad_ts = $urandom;
            if (bad_ts == EXP_TS) bad_ts = ~bad_ts;
            worst = (idb > tsb) ? idb : tsb;
            good  = (worst <= MR);
            npass = good ? worst + 1 : MR + 1;
            exp_flags = {good, !good && idb > MR, !good && tsb > MR, 1'b0};
            exp_cid = (npass <= idb) ? bad_id : EXP_ID;
            exp_cts = (npass <= tsb) ? bad_ts : EXP_TS;
            pulse_start();
            wait_done(ok, b, d2);
            checks++;
            if (!ok || b !== 1'b0 || d2 !== 1'b0 || {pass, err_id, err_ts, err_timeout} !== exp_flags) begin
                failures++;
                $display("FAIL rand_flags it=%0d idb=%0d tsb=%0d done=%b got=%b exp=%b", it, idb, tsb, ok,
                         {pass, err_id, err_ts, err_timeout}, exp_flags);
            end
            checks++;
            if (captured_id !== exp_cid || captured_ts !== exp_cts || !log_alternates(2 * npass) || drop_cnt != 0) begin
                failures++;
                $display("FAIL rand_capture it=%0d got=%h/%h reads=%0d exp=%h/%h reads=%0d", it,
                         captured_id, captured_ts, log_q.size(), exp_cid, exp_cts, 2 * npass);
            end
        end
    endtask

    initial begin
        reset = 1;
        start = 0;
        repeat (3) @(negedge clock);
        test_reset();
        test_auto_boot();
        test_stall();
        test_retry_exhaust();
        test_one_retry();
        test_timeout();
        test_start_ignored();
        test_reset_midcheck();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
